// File: rtl/fetch_controller.sv
// Instruction fetch controller: drives the PC to instruction memory, captures
// returned words into a small FIFO and presents the head to a consumer.
// Redirects flush the buffer and reload the PC.
module fetch_controller #(
    parameter int unsigned   S        = 32,
    parameter logic [S-1:0]  RESET_PC = '0,
    parameter int unsigned   DEPTH    = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         fetch_en,
    output logic [S-1:0] imem_addr,
    input  logic [S-1:0] imem_data,
    input  logic         redirect_valid,
    input  logic [S-1:0] redirect_pc,
    output logic         inst_valid,
    output logic [S-1:0] inst,
    output logic [S-1:0] inst_pc,
    input  logic         inst_ready,
    output logic         misalign
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]   state_q, state_d;
    logic [S-1:0] pc_q, pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic         misalign_q;
    logic [S-1:0] inst_hold_q;
    logic [S-1:0] pc_hold_q;

    logic [S-1:0] buf_inst [DEPTH];
    logic [S-1:0] buf_pc   [DEPTH];

    logic full;
    logic pop;
    logic fetch;

    // Occupancy flags, head selection and fetch/pop qualification.
    always_comb begin
        full       = (count_q == CW'(DEPTH));
        inst_valid = (count_q != '0);
        pop        = inst_valid & inst_ready;
        fetch      = (state_q == RUN) & ~redirect_valid & (~full | pop);
        // An empty buffer keeps showing whatever was last presented.
        inst       = inst_valid ? buf_inst[rd_ptr_q] : inst_hold_q;
        inst_pc    = inst_valid ? buf_pc[rd_ptr_q]   : pc_hold_q;
        imem_addr  = pc_q;
        misalign   = misalign_q;
    end

    // Next-state: FSM, PC, occupancy and pointers; redirect overrides fetch.
    always_comb begin
        state_d  = fetch_en ? RUN : IDLE;
        pc_d     = pc_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (redirect_valid) begin
            pc_d     = {redirect_pc[S-1:2], 2'b00};
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (fetch) begin
                pc_d     = pc_q + S'(4);
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (fetch && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !fetch) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            misalign_q  <= 1'b0;
            inst_hold_q <= '0;
            pc_hold_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            misalign_q  <= redirect_valid & (redirect_pc[1:0] != 2'b00);
            inst_hold_q <= inst;
            pc_hold_q   <= inst_pc;
        end
    end

    // Buffer storage; validity is tracked by count_q, so no reset is needed.
    always_ff @(posedge clk) begin
        if (fetch) begin
            buf_inst[wr_ptr_q] <= imem_data;
            buf_pc[wr_ptr_q]   <= pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios plus random stimulus, all
// checked against a queue-based reference model of the fetch/consume rules.
module tb_fetch_controller;

    localparam int unsigned S        = 32;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int unsigned DEPTH    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        misalign;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [63:0] m_q[$];
    logic [31:0] m_pc;
    bit          m_run;
    bit          m_mis;
    logic [31:0] m_last_inst;
    logic [31:0] m_last_pc;

    fetch_controller #(
        .S(S),
        .RESET_PC(RESET_PC),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .fetch_en(fetch_en),
        .imem_addr(imem_addr),
        .imem_data(imem_data),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .inst_valid(inst_valid),
        .inst(inst),
        .inst_pc(inst_pc),
        .inst_ready(inst_ready),
        .misalign(misalign)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h002081B3;
            32'h4:   return 32'h403202B3;
            32'h8:   return 32'h00308383;
            32'h18:  return 32'h00210463;
            default: return a ^ 32'hA5A5_0F0F ^ {a[15:0], 16'h0};
        endcase
    endfunction

    // Combinational instruction memory.
    always_comb imem_data = mem_word(imem_addr);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc        = RESET_PC;
        m_run       = 0;
        m_mis       = 0;
        m_last_inst = '0;
        m_last_pc   = '0;
    endtask

    task automatic compare_all();
        logic [31:0] e_inst, e_pc;
        e_inst = (m_q.size() > 0) ? m_q[0][63:32] : m_last_inst;
        e_pc   = (m_q.size() > 0) ? m_q[0][31:0]  : m_last_pc;
        check_eq("imem_addr", imem_addr, m_pc);
        check_eq("inst_valid", {31'b0, inst_valid}, {31'b0, m_q.size() > 0});
        check_eq("inst", inst, e_inst);
        check_eq("inst_pc", inst_pc, e_pc);
        check_eq("misalign", {31'b0, misalign}, {31'b0, m_mis});
        m_last_inst = e_inst;
        m_last_pc   = e_pc;
    endtask

    // One clock: advance the model on the current inputs, then compare.
    task automatic step();
        bit do_pop, do_fetch;
        do_pop   = (m_q.size() > 0) && inst_ready;
        do_fetch = m_run && !redirect_valid && ((m_q.size() < DEPTH) || do_pop);
        if (redirect_valid) begin
            m_q.delete();
            m_pc = redirect_pc & 32'hFFFF_FFFC;
        end else begin
            if (do_pop) void'(m_q.pop_front());
            if (do_fetch) begin
                m_q.push_back({mem_word(m_pc), m_pc});
                m_pc = m_pc + 32'd4;
            end
        end
        m_mis = redirect_valid && (redirect_pc[1:0] != 2'b00);
        m_run = fetch_en;
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // Assert reset a little after an edge, check outputs before the next edge.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_eq("rst_addr", imem_addr, RESET_PC);
        check_eq("rst_valid", {31'b0, inst_valid}, 32'h0);
        check_eq("rst_inst", inst, 32'h0);
        check_eq("rst_pc", inst_pc, 32'h0);
        check_eq("rst_mis", {31'b0, misalign}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        reset = 1'b0;

        // Straight-line fetch stream.
        fetch_en   = 1'b1;
        inst_ready = 1'b1;
        step();
        check_eq("first_idle", {31'b0, inst_valid}, 32'h0);
        step();
        check_eq("s0_inst", inst, 32'h002081B3);
        check_eq("s0_pc", inst_pc, 32'h0);
        step();
        check_eq("s1_inst", inst, 32'h403202B3);
        check_eq("s1_pc", inst_pc, 32'h4);
        step();
        check_eq("s2_inst", inst, 32'h00308383);
        check_eq("s2_pc", inst_pc, 32'h8);

        // Stalled consumer fills the buffer and freezes the PC.
        inst_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) step();
        check_eq("stall_addr", imem_addr, RESET_PC + 32'(4 * DEPTH));
        check_eq("stall_valid", {31'b0, inst_valid}, 32'h1);
        check_eq("stall_head", inst_pc, RESET_PC);

        // Release: full buffer streams one push and one pop per cycle.
        inst_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq("drain_pc", inst_pc, 32'(4 + 4 * k));
            check_eq("drain_addr", imem_addr, 32'(12 + 4 * k));
        end

        // Redirect with two entries buffered.
        inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h18;
        step();
        check_eq("redir_valid", {31'b0, inst_valid}, 32'h0);
        check_eq("redir_addr", imem_addr, 32'h18);
        redirect_valid = 1'b0;
        step();
        check_eq("redir_inst", inst, 32'h00210463);
        check_eq("redir_pc", inst_pc, 32'h18);

        // Misaligned target and PC wrap.
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h33;
        step();
        check_eq("mis_addr", imem_addr, 32'h30);
        check_eq("mis_hi", {31'b0, misalign}, 32'h1);
        redirect_valid = 1'b0;
        step();
        check_eq("mis_lo", {31'b0, misalign}, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        check_eq("wrap_a0", imem_addr, 32'hFFFF_FFFC);
        redirect_valid = 1'b0;
        step();
        check_eq("wrap_a1", imem_addr, 32'h0);
        check_eq("wrap_head", inst_pc, 32'hFFFF_FFFC);

        // Asynchronous reset mid-cycle with a full buffer.
        inst_ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check_eq("pre_rst_valid", {31'b0, inst_valid}, 32'h1);
        do_reset();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            fetch_en       = ($urandom_range(0, 9) != 0);
            inst_ready     = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = $urandom;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
